cordic_iter_ctrl: RTL

//  Iterative CORDIC engine: instantiates one cordic_stage and reuses it for N_ITER cycles.
//  Per iteration: registers x/y/z, drives shift index i and atan(2^-i) from an internal ROM.

---
 rtl/cordic_iter_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/cordic_iter_ctrl.sv
// -----------------------------------------------------------------------------
// cordic_iter_ctrl
//   Iterative CORDIC engine. A single combinational cordic_stage is reused for
//   N_ITER clock cycles per operation; x/y/z are held in registers between
//   iterations. The stage is fed the shift index i = iter and the angle
//   phi = atan(2^-iter) taken from a small constant ROM. No gain compensation
//   is applied, so magnitudes leave the engine scaled by K ~ 1.6468.
//
//   Angles are Q2.15 radians (32768 = 1 rad). x/y are 19-bit signed, z 18-bit.
//
// Ports
//   clk        rising-edge clock for all state
//   rst_n      synchronous reset, active low
//   in_valid   operand valid            in_ready   engine idle, can accept
//   mode       0 = rotation (z -> 0), 1 = vectoring (y -> 0), latched on accept
//   x_in/y_in  signed initial vector    z_in       signed initial angle
//   out_valid  result valid (DONE)      out_ready  consumer accepts result
//   x_out/y_out/z_out  working registers, valid only while out_valid is high
//   busy       high in RUN or DONE
// -----------------------------------------------------------------------------

// One CORDIC micro-rotation. Purely combinational.
//   rotation : d = sign(z)           (z >= 0 -> d = +1)
//   vectoring: d = -sign(y)          (y >= 0 -> d = -1)
//   x' = x - d*(y >>> i),  y' = y + d*(x >>> i),  z' = z - d*phi
module cordic_stage (
  input  logic signed [18:0] x,
  input  logic signed [18:0] y,
  input  logic signed [17:0] z,
  input  logic signed [17:0] phi,
  input  logic        [3:0]  i,
  input  logic               rot0_vec1,
  output logic signed [18:0] x_next,
  output logic signed [18:0] y_next,
  output logic signed [17:0] z_next
);

  logic               neg_dir;  // d = -1 this step
  logic signed [18:0] x_sh;
  logic signed [18:0] y_sh;

  // NOTE: every variable driven here gets a value on every path, assigned
  // first as a default, so no latches are inferred.
  always_comb begin
    neg_dir = 1'b0;
    x_sh    = x >>> i;
    y_sh    = y >>> i;
    x_next  = x;
    y_next  = y;
    z_next  = z;

    neg_dir = rot0_vec1 ? ~y[18] : z[17];

    // Arithmetic wraps at the register width; callers keep inputs in range.
    if (neg_dir) begin
      x_next = x + y_sh;
      y_next = y - x_sh;
      z_next = z + phi;
    end else begin
      x_next = x - y_sh;
      y_next = y + x_sh;
      z_next = z - phi;
    end
  end

endmodule

module cordic_iter_ctrl #(
  parameter int N_ITER = 16  // iterations per operation, 1..16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               mode,
  input  logic signed [18:0] x_in,
  input  logic signed [18:0] y_in,
  input  logic signed [17:0] z_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [18:0] x_out,
  output logic signed [18:0] y_out,
  output logic signed [17:0] z_out,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_ITER = 4'(N_ITER - 1);

  // round(atan(2^-k) * 32768); entries at or beyond N_ITER are never selected.
  localparam logic signed [17:0] ATAN [16] = '{
    18'sd25736, 18'sd15193, 18'sd8027, 18'sd4075,
    18'sd2045,  18'sd1024,  18'sd512,  18'sd256,
    18'sd128,   18'sd64,    18'sd32,   18'sd16,
    18'sd8,     18'sd4,     18'sd2,    18'sd1
  };

  state_t             state;
  state_t             state_nx;
  logic        [3:0]  iter;
  logic               mode_r;
  logic signed [18:0] x_r;
  logic signed [18:0] y_r;
  logic signed [17:0] z_r;

  logic signed [18:0] x_st;
  logic signed [18:0] y_st;
  logic signed [17:0] z_st;

  logic accept;
  logic release_out;

  cordic_stage u_stage (
    .x         (x_r),
    .y         (y_r),
    .z         (z_r),
    .phi       (ATAN[iter]),
    .i         (iter),
    .rot0_vec1 (mode_r),
    .x_next    (x_st),
    .y_next    (y_st),
    .z_next    (z_st)
  );

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign accept      = in_valid && in_ready;
  assign release_out = out_valid && out_ready;

  assign x_out = x_r;
  assign y_out = y_r;
  assign z_out = z_r;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (iter == LAST_ITER) state_nx = DONE;
      DONE:    if (release_out) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch; all
  // working registers are cleared so a mid-operation reset leaves nothing
  // stale on x/y/z_out.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, matching the hardware it describes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      iter   <= '0;
      mode_r <= 1'b0;
      x_r    <= '0;
      y_r    <= '0;
      z_r    <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (accept) begin
            x_r    <= x_in;
            y_r    <= y_in;
            z_r    <= z_in;
            mode_r <= mode;
            iter   <= '0;
          end
        end
        RUN: begin
          x_r  <= x_st;
          y_r  <= y_st;
          z_r  <= z_st;
          iter <= iter + 4'd1;
        end
        default: ;  // DONE holds the result until it is taken
      endcase
    end
  end

endmodule
